// File: rtl/tpu_pkg.sv
// Shared TPU definitions: MAC word-format defaults and the MAC sequencer state type.
package tpu_pkg;

  localparam int N_DEF = 32;
  localparam int Q_DEF = 10;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_CLEAR  = 3'd1,
    S_STREAM = 3'd2,
    S_DRAIN1 = 3'd3,
    S_DRAIN2 = 3'd4,
    S_RESULT = 3'd5
  } mac_seq_state_t;

endpackage

// File: rtl/operand_addr_gen.sv
// Operand index counter shared by the A and B SRAMs; each side adds its own base,
// wrapping modulo 2^ADDR_W.
module operand_addr_gen #(
  parameter int ADDR_W = 8,
  parameter int LEN_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              step,
  input  logic [LEN_W-1:0]  len,
  input  logic [ADDR_W-1:0] a_base,
  input  logic [ADDR_W-1:0] b_base,
  output logic [ADDR_W-1:0] a_addr,
  output logic [ADDR_W-1:0] b_addr,
  output logic              last,
  output logic              empty
);

  localparam logic [LEN_W-1:0]  LEN_ZERO  = {LEN_W{1'b0}};
  localparam logic [LEN_W-1:0]  LEN_ONE   = {{(LEN_W-1){1'b0}}, 1'b1};
  localparam logic [ADDR_W-1:0] ADDR_ZERO = {ADDR_W{1'b0}};

  logic [LEN_W-1:0]  len_r;
  logic [LEN_W-1:0]  idx_r;
  logic [LEN_W-1:0]  idx_nxt_s;
  logic [ADDR_W-1:0] a_base_r;
  logic [ADDR_W-1:0] b_base_r;
  logic [ADDR_W-1:0] a_addr_r;
  logic [ADDR_W-1:0] b_addr_r;

  function automatic logic [ADDR_W-1:0] wrap_add(input logic [ADDR_W-1:0] base,
                                                 input logic [LEN_W-1:0]  idx);
    return base + ADDR_W'(idx);
  endfunction

  assign idx_nxt_s = idx_r + LEN_ONE;

  // Latch the job on load, then advance index and both addresses on each step.
  always_ff @(posedge clk) begin
    if (rst) begin
      len_r    <= LEN_ZERO;
      idx_r    <= LEN_ZERO;
      a_base_r <= ADDR_ZERO;
      b_base_r <= ADDR_ZERO;
      a_addr_r <= ADDR_ZERO;
      b_addr_r <= ADDR_ZERO;
    end else if (load) begin
      len_r    <= len;
      idx_r    <= LEN_ZERO;
      a_base_r <= a_base;
      b_base_r <= b_base;
      a_addr_r <= a_base;
      b_addr_r <= b_base;
    end else if (step) begin
      idx_r    <= idx_nxt_s;
      a_addr_r <= wrap_add(a_base_r, idx_nxt_s);
      b_addr_r <= wrap_add(b_base_r, idx_nxt_s);
    end
  end

  assign a_addr = a_addr_r;
  assign b_addr = b_addr_r;
  assign last   = (idx_r == (len_r - LEN_ONE));
  assign empty  = (len_r == LEN_ZERO);

endmodule

// File: rtl/mac_seq_ctrl.sv
// Dot-product sequencer: takes a job, streams operand pairs from two SRAMs into an
// external MAC, and returns the final accumulator plus a sticky overflow flag.
module mac_seq_ctrl
  import tpu_pkg::*;
#(
  parameter int N      = N_DEF,
  parameter int Q      = Q_DEF,
  parameter int ADDR_W = 8,
  parameter int LEN_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              job_valid,
  output logic              job_ready,
  input  logic [LEN_W-1:0]  job_len,
  input  logic [ADDR_W-1:0] job_a_base,
  input  logic [ADDR_W-1:0] job_b_base,
  output logic              rd_en,
  output logic [ADDR_W-1:0] a_addr,
  output logic [ADDR_W-1:0] b_addr,
  input  logic [N-1:0]      a_data,
  input  logic [N-1:0]      b_data,
  output logic              mac_clr,
  output logic              mac_en,
  input  logic [N-1:0]      mac_out,
  input  logic              mac_ovr,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [N-1:0]      res_data,
  output logic              res_ovr,
  output logic              busy
);

  mac_seq_state_t state_r;
  logic           rd_en_r;
  logic           mac_en_r;
  logic           mac_clr_r;
  logic           res_valid_r;
  logic           res_ovr_r;
  logic           sticky_r;
  logic [N-1:0]   res_data_r;
  logic           load_s;
  logic           step_s;
  logic           last_s;
  logic           empty_s;
  logic           unused_s;

  // Operand data goes straight from the SRAMs to the MAC; it only appears here for interface symmetry.
  assign unused_s = ^{a_data, b_data, (Q >= N)};

  operand_addr_gen #(
    .ADDR_W (ADDR_W),
    .LEN_W  (LEN_W)
  ) u_addr_gen (
    .clk    (clk),
    .rst    (rst),
    .load   (load_s),
    .step   (step_s),
    .len    (job_len),
    .a_base (job_a_base),
    .b_base (job_b_base),
    .a_addr (a_addr),
    .b_addr (b_addr),
    .last   (last_s),
    .empty  (empty_s)
  );

  // Address generator control: load on job acceptance, step while streaming.
  always_comb begin
    load_s = 1'b0;
    step_s = 1'b0;
    if (state_r == S_IDLE) begin
      load_s = job_valid;
    end else if (state_r == S_STREAM) begin
      step_s = ~last_s;
    end else begin
      load_s = 1'b0;
      step_s = 1'b0;
    end
  end

  // Sequencer FSM with registered strobes; mac_en trails rd_en by the SRAM read latency.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= S_IDLE;
      rd_en_r     <= 1'b0;
      mac_en_r    <= 1'b0;
      mac_clr_r   <= 1'b0;
      res_valid_r <= 1'b0;
      res_ovr_r   <= 1'b0;
      sticky_r    <= 1'b0;
      res_data_r  <= {N{1'b0}};
    end else begin
      mac_en_r  <= rd_en_r;
      mac_clr_r <= 1'b0;
      if (mac_en_r) begin
        sticky_r <= sticky_r | mac_ovr;
      end
      case (state_r)
        S_IDLE: begin
          if (job_valid) begin
            sticky_r  <= 1'b0;
            mac_clr_r <= 1'b1;
            state_r   <= S_CLEAR;
          end
        end
        S_CLEAR: begin
          if (empty_s) begin
            res_data_r  <= {N{1'b0}};
            res_ovr_r   <= 1'b0;
            res_valid_r <= 1'b1;
            state_r     <= S_RESULT;
          end else begin
            rd_en_r <= 1'b1;
            state_r <= S_STREAM;
          end
        end
        S_STREAM: begin
          if (last_s) begin
            rd_en_r <= 1'b0;
            state_r <= S_DRAIN1;
          end
        end
        S_DRAIN1: begin
          state_r <= S_DRAIN2;
        end
        S_DRAIN2: begin
          res_data_r  <= mac_out;
          res_ovr_r   <= sticky_r;
          res_valid_r <= 1'b1;
          state_r     <= S_RESULT;
        end
        S_RESULT: begin
          if (res_ready) begin
            res_valid_r <= 1'b0;
            state_r     <= S_IDLE;
          end
        end
        default: begin
          rd_en_r     <= 1'b0;
          res_valid_r <= 1'b0;
          state_r     <= S_IDLE;
        end
      endcase
    end
  end

  assign job_ready = (state_r == S_IDLE);
  assign busy      = (state_r != S_IDLE);
  assign rd_en     = rd_en_r;
  assign mac_en    = mac_en_r;
  assign mac_clr   = mac_clr_r;
  assign res_valid = res_valid_r;
  assign res_data  = res_data_r;
  assign res_ovr   = res_ovr_r;

endmodule
